immgen_pipe: RTL and testbench
==============================

# immgen_pipe

Parametrised, pipelined immediate generator for the Xenyx-4 decode stage. It takes a fetched instruction with a sideband tag over a valid/ready handshake and extracts and sign-extends the I/S/B/U/J immediate to XLEN. It classifies the instruction format and flags unsupported opcodes. A one-entry skid buffer gives full throughput under backpressure, and a synchronous flush clears both entries on redirect.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- TAG_W, 8: width of the sideband tag (core ID / ROB slot) carried alongside the instruction.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all held entries and any same-cycle input.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR-zimm, 7 illegal.
- out_illegal  out  1  equals (out_fmt == 7).
- out_tag  out  TAG_W  tag of the presented result.

## Operation
- Decode is combinational on in_instr and uses opcode [6:0]. The result is registered into the output entry, or into the skid entry if the output entry is stalled.
- I-type, imm = sext(instr[31:20]), opcodes:
  - 0000011 (load)
  - 0010011 (op-imm)
  - 1100111 (jalr)
  - 1110011 (system)
  - 0011011 (op-imm-32, XLEN=64 only)
- Shifts (op-imm funct3 001/101) are also I-type but with imm = zero-extended shamt: instr[24:20] for XLEN=32, instr[25:20] for XLEN=64. For XLEN=32, shift with instr[25]=1 → illegal.
- S-type 0100011: sext({instr[31:25],instr[11:7]}).
- B-type 1100011: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
- U-type 0110111/0010111: sext({instr[31:12],12'b0}); sign bit is instr[31] for XLEN=64.
- J-type 1101111: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
- R-type 0110011 (and 0111011 if XLEN=64): imm = 0.
- Any other opcode, op-imm-32/op-32 when XLEN=32, or instr[1:0] != 2'b11 → fmt 7, imm 0, illegal 1.
- Skid buffer:
  - Entries: OUT (drives outputs) and SKID.
  - States: EMPTY (neither valid), ONE (OUT valid), FULL (both valid).
  - EMPTY + accept → ONE.
  - ONE + accept + stall → FULL.
  - ONE + drain without accept → EMPTY.
  - ONE + accept + drain → ONE (OUT overwritten).
  - FULL + drain → ONE (SKID moves to OUT).
  - in_ready = !SKID.valid, registered. No input is accepted in FULL.
- Ordering strictly FIFO; no result lost or duplicated.
- flush: next state EMPTY regardless of handshake; same-cycle in_valid dropped; flush has priority over accept and drain.

## Timing
- Reset values:
  - out_valid 0
  - in_ready 1
  - out_imm 0
  - out_fmt 0
  - out_illegal 0
  - out_tag 0
- Latency: accepted at edge N → out_valid at N+1 with that result.
- Throughput: 1 instruction/cycle while out_ready=1.
- out_* stable while out_valid=1 && out_ready=0.
- in_ready drops the cycle after SKID fills. It returns the cycle after SKID drains into OUT, or after flush.
- Reset asserted mid-operation clears both entries immediately (asynchronous); in_ready=1 after release.

## Configuration
- IMMGEN_ZICSR_EN defined: system opcode with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) → fmt 6, imm = zero-extended instr[19:15]. funct3 100 → illegal. Other system encodings remain I-type.
- Undefined: all system opcodes decode as I-type sign-extended instr[31:20]; fmt 6 never produced.

## Test plan
- XLEN=32, 0xFFF00093 (addi x1,x0,-1), tag 0x5A, out_ready=1 → next cycle imm 0xFFFFFFFF, fmt 1, tag 0x5A. Then 0xFE112E23 (sw x1,-4(x2)) → 0xFFFFFFFC, fmt 2.
- XLEN=64: 0x800000B7 (lui x1,0x80000) → 0xFFFFFFFF80000000, fmt 4; 0x02009093 (slli x1,x1,32) → imm 32, fmt 1. Same slli with XLEN=32 → fmt 7.
- Backpressure: out_ready=0 while presenting A, B, C back-to-back → A, B accepted, in_ready=0 during C. Release out_ready → A, B, C emitted in order on consecutive cycles, C accepted one cycle after B leaves SKID.
- Flush in FULL with in_valid=1 → out_valid=0 and in_ready=1 next cycle; nothing emitted from held or flushed input.
- 0x0000007F and 0x00000013 with instr[1:0] forced to 01 → fmt 7, illegal 1, imm 0.
- 0x300FD073 (csrrwi x0,0x300,31): with IMMGEN_ZICSR_EN → imm 31, fmt 6. Without → imm 0x300, fmt 1.

Source files
------------

// File: rtl/immgen_pipe_if.sv
// Handshake bundle for immgen_pipe: instruction/tag in, extended immediate/format/tag out.
// master drives the instruction side and consumes results; slave is the generator.
interface immgen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/immgen_pipe.sv
// Pipelined immediate generator with a one-entry skid buffer and synchronous flush.
// Optional feature macro: IMMGEN_ZICSR_EN (CSR immediate forms decode as fmt 6).
module immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    immgen_pipe_if.slave bus
);
    localparam bit IS64 = (XLEN == 64);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_CSR = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    logic [31:0]      w_instr;
    logic [2:0]       w_funct3;
    logic [63:0]      w_sext_i;
    logic [63:0]      w_imm64;
    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_skid_to_out;

    logic             r_out_valid;
    logic             r_in_ready;
    logic [XLEN-1:0]  r_out_imm;
    logic [2:0]       r_out_fmt;
    logic [TAG_W-1:0] r_out_tag;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic [TAG_W-1:0] r_skid_tag;

    assign w_instr  = bus.in_instr;
    assign w_funct3 = w_instr[14:12];
    assign w_sext_i = {{52{w_instr[31]}}, w_instr[31:20]};
    // Build every immediate at 64 bits and truncate, so one decoder serves both widths.
    assign w_imm    = w_imm64[XLEN-1:0];

    // Combinational format classification and immediate extraction.
    always_comb begin
        w_imm64 = 64'd0;
        w_fmt   = FMT_ILL;
        if (w_instr[1:0] != 2'b11) begin
            w_imm64 = 64'd0;
            w_fmt   = FMT_ILL;
        end else begin
            case (w_instr[6:0])
                7'b0000011, 7'b1100111: begin
                    w_imm64 = w_sext_i;
                    w_fmt   = FMT_I;
                end
                7'b0010011: begin
                    if (w_funct3[1:0] == 2'b01) begin
                        if (IS64) begin
                            w_imm64 = {58'd0, w_instr[25:20]};
                            w_fmt   = FMT_I;
                        end else if (w_instr[25]) begin
                            w_imm64 = 64'd0;
                            w_fmt   = FMT_ILL;
                        end else begin
                            w_imm64 = {59'd0, w_instr[24:20]};
                            w_fmt   = FMT_I;
                        end
                    end else begin
                        w_imm64 = w_sext_i;
                        w_fmt   = FMT_I;
                    end
                end
                7'b1110011: begin
`ifdef IMMGEN_ZICSR_EN
                    if (w_funct3 == 3'b100) begin
                        w_imm64 = 64'd0;
                        w_fmt   = FMT_ILL;
                    end else if (w_funct3[2]) begin
                        w_imm64 = {59'd0, w_instr[19:15]};
                        w_fmt   = FMT_CSR;
                    end else begin
                        w_imm64 = w_sext_i;
                        w_fmt   = FMT_I;
                    end
`else
                    w_imm64 = w_sext_i;
                    w_fmt   = FMT_I;
`endif
                end
                7'b0011011: begin
                    if (IS64) begin
                        w_imm64 = w_sext_i;
                        w_fmt   = FMT_I;
                    end else begin
                        w_imm64 = 64'd0;
                        w_fmt   = FMT_ILL;
                    end
                end
                7'b0100011: begin
                    w_imm64 = {{52{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                    w_fmt   = FMT_S;
                end
                7'b1100011: begin
                    w_imm64 = {{52{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
                    w_fmt   = FMT_B;
                end
                7'b0110111, 7'b0010111: begin
                    w_imm64 = {{32{w_instr[31]}}, w_instr[31:12], 12'd0};
                    w_fmt   = FMT_U;
                end
                7'b1101111: begin
                    w_imm64 = {{44{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
                    w_fmt   = FMT_J;
                end
                7'b0110011: begin
                    w_imm64 = 64'd0;
                    w_fmt   = FMT_R;
                end
                7'b0111011: begin
                    w_imm64 = 64'd0;
                    w_fmt   = IS64 ? FMT_R : FMT_ILL;
                end
                default: begin
                    w_imm64 = 64'd0;
                    w_fmt   = FMT_ILL;
                end
            endcase
        end
    end

    assign w_accept = bus.in_valid && r_in_ready && !flush;
    assign w_drain  = r_out_valid && bus.out_ready;

    // Skid-buffer next state and entry load controls; flush overrides any handshake.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_load_out  = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_state_nxt = ST_ONE;
                        w_load_out  = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_state_nxt   = ST_ONE;
                        w_skid_to_out = 1'b1;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State register with registered valid/ready derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
        end
    end

    // OUT entry payload: fresh decode or the older SKID result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_imm <= '0;
            r_out_fmt <= 3'd0;
            r_out_tag <= '0;
        end else if (w_load_out) begin
            r_out_imm <= w_imm;
            r_out_fmt <= w_fmt;
            r_out_tag <= bus.in_tag;
        end else if (w_skid_to_out) begin
            r_out_imm <= r_skid_imm;
            r_out_fmt <= r_skid_fmt;
            r_out_tag <= r_skid_tag;
        end
    end

    // SKID entry payload, captured only when OUT is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_imm <= '0;
            r_skid_fmt <= 3'd0;
            r_skid_tag <= '0;
        end else if (w_load_skid) begin
            r_skid_imm <= w_imm;
            r_skid_fmt <= w_fmt;
            r_skid_tag <= bus.in_tag;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_imm     = r_out_imm;
    assign bus.out_fmt     = r_out_fmt;
    assign bus.out_illegal = (r_out_fmt == FMT_ILL);
    assign bus.out_tag     = r_out_tag;
endmodule

// File: tb/tb_immgen_pipe.sv
// Directed-vector bench for immgen_pipe: one XLEN=32 and one XLEN=64 instance.
module tb_immgen_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    immgen_pipe_if #(.XLEN(32), .TAG_W(8)) if32 ();
    immgen_pipe_if #(.XLEN(64), .TAG_W(8)) if64 ();

    immgen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32.slave));
    immgen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit w64, input logic [31:0] instr, input logic [7:0] tag,
                        input logic [63:0] exp_imm, input logic [2:0] exp_fmt, input string name);
        if (w64) begin
            if64.in_valid = 1'b1; if64.in_instr = instr; if64.in_tag = tag;
        end else begin
            if32.in_valid = 1'b1; if32.in_instr = instr; if32.in_tag = tag;
        end
        tick();
        if32.in_valid = 1'b0;
        if64.in_valid = 1'b0;
        if (w64) begin
            check({name, "/valid"}, {63'd0, if64.out_valid}, 64'd1);
            check({name, "/imm"},   if64.out_imm, exp_imm);
            check({name, "/fmt"},   {61'd0, if64.out_fmt}, {61'd0, exp_fmt});
            check({name, "/ill"},   {63'd0, if64.out_illegal}, {63'd0, (exp_fmt == 3'd7)});
            check({name, "/tag"},   {56'd0, if64.out_tag}, {56'd0, tag});
        end else begin
            check({name, "/valid"}, {63'd0, if32.out_valid}, 64'd1);
            check({name, "/imm"},   {32'd0, if32.out_imm}, exp_imm);
            check({name, "/fmt"},   {61'd0, if32.out_fmt}, {61'd0, exp_fmt});
            check({name, "/ill"},   {63'd0, if32.out_illegal}, {63'd0, (exp_fmt == 3'd7)});
            check({name, "/tag"},   {56'd0, if32.out_tag}, {56'd0, tag});
        end
    endtask

    initial begin
        if32.in_valid = 1'b0; if32.in_instr = 32'd0; if32.in_tag = 8'd0; if32.out_ready = 1'b1;
        if64.in_valid = 1'b0; if64.in_instr = 32'd0; if64.in_tag = 8'd0; if64.out_ready = 1'b1;

        #12;
        check("rst/valid", {63'd0, if32.out_valid}, 64'd0);
        check("rst/ready", {63'd0, if32.in_ready}, 64'd1);
        check("rst/imm",   {32'd0, if32.out_imm}, 64'd0);
        check("rst/fmt",   {61'd0, if32.out_fmt}, 64'd0);
        check("rst/ill",   {63'd0, if32.out_illegal}, 64'd0);
        check("rst/tag",   {56'd0, if32.out_tag}, 64'd0);
        check("rst64/imm", if64.out_imm, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(1'b0, 32'hFFF00093, 8'h5A, 64'h00000000FFFFFFFF, 3'd1, "addi32");
        send(1'b0, 32'hFE112E23, 8'h11, 64'h00000000FFFFFFFC, 3'd2, "sw32");
        send(1'b0, 32'hFE000EE3, 8'h12, 64'h00000000FFFFFFFC, 3'd3, "beq32");
        send(1'b0, 32'h0080006F, 8'h13, 64'h0000000000000008, 3'd5, "jal32");
        send(1'b0, 32'h002081B3, 8'h14, 64'h0000000000000000, 3'd0, "add32");
        send(1'b0, 32'h4010D093, 8'h15, 64'h0000000000000001, 3'd1, "srai32");
        send(1'b0, 32'h02009093, 8'h16, 64'h0000000000000000, 3'd7, "slli32_wide");
        send(1'b0, 32'h0000001B, 8'h17, 64'h0000000000000000, 3'd7, "addiw32");
        send(1'b0, 32'h0000007F, 8'h18, 64'h0000000000000000, 3'd7, "badop");
        send(1'b0, 32'h00000011, 8'h19, 64'h0000000000000000, 3'd7, "lowbits");
`ifdef IMMGEN_ZICSR_EN
        send(1'b0, 32'h300FD073, 8'h1A, 64'h000000000000001F, 3'd6, "csrrwi");
`else
        send(1'b0, 32'h300FD073, 8'h1A, 64'h0000000000000300, 3'd1, "csrrwi");
`endif

        send(1'b1, 32'h800000B7, 8'h21, 64'hFFFFFFFF80000000, 3'd4, "lui64");
        send(1'b1, 32'h02009093, 8'h22, 64'h0000000000000020, 3'd1, "slli64");
        send(1'b1, 32'hFFF0009B, 8'h23, 64'hFFFFFFFFFFFFFFFF, 3'd1, "addiw64");
        send(1'b1, 32'h002081BB, 8'h24, 64'h0000000000000000, 3'd0, "addw64");

        // Backpressure: A and B fill OUT and SKID, C waits until SKID drains.
        tick();
        if32.out_ready = 1'b0;
        if32.in_valid = 1'b1; if32.in_instr = 32'h00100093; if32.in_tag = 8'hA1;
        tick();
        check("bp/ready_one", {63'd0, if32.in_ready}, 64'd1);
        check("bp/tagA",      {56'd0, if32.out_tag}, 64'hA1);
        if32.in_instr = 32'h00200113; if32.in_tag = 8'hB2;
        tick();
        check("bp/ready_full", {63'd0, if32.in_ready}, 64'd0);
        check("bp/holdA",      {56'd0, if32.out_tag}, 64'hA1);
        if32.in_instr = 32'h00300193; if32.in_tag = 8'hC3;
        tick();
        check("bp/stableA",   {32'd0, if32.out_imm}, 64'd1);
        check("bp/ready_low", {63'd0, if32.in_ready}, 64'd0);
        if32.out_ready = 1'b1;
        tick();
        check("bp/tagB",    {56'd0, if32.out_tag}, 64'hB2);
        check("bp/immB",    {32'd0, if32.out_imm}, 64'd2);
        check("bp/ready_b", {63'd0, if32.in_ready}, 64'd1);
        tick();
        if32.in_valid = 1'b0;
        check("bp/tagC",   {56'd0, if32.out_tag}, 64'hC3);
        check("bp/immC",   {32'd0, if32.out_imm}, 64'd3);
        check("bp/validC", {63'd0, if32.out_valid}, 64'd1);
        tick();
        check("bp/drained", {63'd0, if32.out_valid}, 64'd0);

        // Flush while FULL with a same-cycle input.
        if32.out_ready = 1'b0;
        if32.in_valid = 1'b1; if32.in_instr = 32'h00100093; if32.in_tag = 8'hD1;
        tick();
        if32.in_tag = 8'hD2;
        tick();
        check("fl/full", {63'd0, if32.in_ready}, 64'd0);
        if32.in_tag = 8'hD3;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if32.in_valid = 1'b0;
        check("fl/valid", {63'd0, if32.out_valid}, 64'd0);
        check("fl/ready", {63'd0, if32.in_ready}, 64'd1);
        if32.out_ready = 1'b1;
        tick();
        check("fl/empty", {63'd0, if32.out_valid}, 64'd0);

        // Asynchronous reset mid-operation.
        if32.out_ready = 1'b0;
        if32.in_valid = 1'b1; if32.in_tag = 8'hE1;
        tick();
        check("ar/held", {63'd0, if32.out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar/valid", {63'd0, if32.out_valid}, 64'd0);
        check("ar/tag",   {56'd0, if32.out_tag}, 64'd0);
        if32.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ar/ready", {63'd0, if32.in_ready}, 64'd1);
        check("ar/empty", {63'd0, if32.out_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
